// File: rtl/lru_pkg.sv
// Shared helpers for the per-set LRU tracker.
// Provides clog2 and set_w for width derivation, plus default-configuration widths and way type.
// Modules with other WAYS/SETS values derive their own widths through the same helpers.
package lru_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Set index width; at least one bit even for a single-set cache.
    function automatic int set_w(input int sets);
        return (clog2(sets) < 1) ? 1 : clog2(sets);
    endfunction

    localparam int WAYS_DFLT = 4;
    localparam int SETS_DFLT = 16;
    localparam int WAY_W     = clog2(WAYS_DFLT);
    localparam int SET_W     = set_w(SETS_DFLT);

    typedef logic [WAY_W-1:0] way_t;

endpackage

// File: rtl/lru_sets_if.sv
// Controller-side bundle for the LRU tracker: touch, invalidate, and query/victim lookup.
// master = cache controller (drives requests, reads lru_way/mru_way); slave = lru_sets.
// All signals are single-cycle, no handshake; results are combinational from state.
interface lru_sets_if import lru_pkg::*; #(
    parameter int WAYS = 4,
    parameter int SETS = 16
);
    localparam int WAY_BITS = clog2(WAYS);
    localparam int SET_BITS = set_w(SETS);

    logic                touch_en;
    logic [SET_BITS-1:0] touch_set;
    logic [WAY_BITS-1:0] touch_way;
    logic                inv_en;
    logic [SET_BITS-1:0] inv_set;
    logic [WAY_BITS-1:0] inv_way;
    logic [SET_BITS-1:0] query_set;
    logic [WAY_BITS-1:0] lru_way;
    logic [WAY_BITS-1:0] mru_way;

    modport master (
        output touch_en, touch_set, touch_way,
        output inv_en, inv_set, inv_way, query_set,
        input  lru_way, mru_way
    );

    modport slave (
        input  touch_en, touch_set, touch_way,
        input  inv_en, inv_set, inv_way, query_set,
        output lru_way, mru_way
    );

endinterface

// File: rtl/lru_set_order.sv
// One set's MRU->LRU way order with touch (promote to MRU) and invalidate (demote to LRU).
// Ports: clk, rst_n, touch_en_i/touch_way_i, inv_en_i/inv_way_i in; lru_o, mru_o, order_o out.
// Update lands on the next posedge; touch has priority if both enables are set.
module lru_set_order import lru_pkg::*; #(
    parameter int WAYS = 4,
    parameter int WAY_BITS = clog2(WAYS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     touch_en_i,
    input  logic [WAY_BITS-1:0]      touch_way_i,
    input  logic                     inv_en_i,
    input  logic [WAY_BITS-1:0]      inv_way_i,
    output logic [WAY_BITS-1:0]      lru_o,
    output logic [WAY_BITS-1:0]      mru_o,
    output logic [WAYS*WAY_BITS-1:0] order_o
);

    logic [WAY_BITS-1:0] order_q [WAYS];
    logic [WAY_BITS-1:0] order_d [WAYS];
    logic [WAYS-1:0]     t_ge;   // t_ge[i]: touched way sits at position >= i
    logic [WAYS-1:0]     i_le;   // i_le[i]: invalidated way sits at position <= i

    always_comb begin
        logic t_acc;
        logic i_acc;
        t_acc = 1'b0;
        i_acc = 1'b0;
        t_ge  = '0;
        i_le  = '0;
        for (int p = WAYS - 1; p >= 0; p--) begin
            t_acc   = t_acc | (order_q[p] == touch_way_i);
            t_ge[p] = t_acc;
        end
        for (int p = 0; p < WAYS; p++) begin
            i_acc   = i_acc | (order_q[p] == inv_way_i);
            i_le[p] = i_acc;
        end
    end

    // Touch: positions up to the hit slide one toward LRU, hit goes to MRU.
    // Invalidate: positions from the hit onward slide one toward MRU, hit goes to LRU.
    // A hit already at the target end reproduces the current order.
    always_comb begin
        order_d = order_q;
        if (touch_en_i) begin
            order_d[0] = touch_way_i;
            for (int i = 1; i < WAYS; i++) begin
                if (t_ge[i]) begin
                    order_d[i] = order_q[i-1];
                end
            end
        end else if (inv_en_i) begin
            order_d[WAYS-1] = inv_way_i;
            for (int i = 0; i < WAYS - 1; i++) begin
                if (i_le[i]) begin
                    order_d[i] = order_q[i+1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int p = 0; p < WAYS; p++) begin
                order_q[p] <= WAY_BITS'(p);
            end
        end else begin
            order_q <= order_d;
        end
    end

    assign mru_o = order_q[0];
    assign lru_o = order_q[WAYS-1];

    always_comb begin
        for (int p = 0; p < WAYS; p++) begin
            order_o[p*WAY_BITS +: WAY_BITS] = order_q[p];
        end
    end

endmodule

// File: rtl/lru_sets.sv
// Per-set true-LRU tracker: SETS independent MRU->LRU way lists beside the tag array.
// Ports: clk, rst_n (sync, active-low); bus (slave) carries touch/inv requests and query results.
// Updates take effect at the next posedge; lru_way/mru_way are combinational, no backpressure.
module lru_sets import lru_pkg::*; #(
    parameter int WAYS  = 4,
    parameter int SETS  = 16,
    parameter bit DEBUG = 1'b0   // 1 = check set consistency every cycle in simulation
) (
    input  logic      clk,
    input  logic      rst_n,
    lru_sets_if.slave bus
);

    localparam int WAY_BITS = clog2(WAYS);

    logic [SETS-1:0]          t_en;
    logic [SETS-1:0]          i_en;
    logic [WAY_BITS-1:0]      lru_s [SETS];
    logic [WAY_BITS-1:0]      mru_s [SETS];
    logic [WAYS*WAY_BITS-1:0] ord_s [SETS];
    logic [SETS-1:0]          perm_ok;
    logic                     same_set;

    // Same-set collision drops the invalidate. Out-of-range indices match no set.
    assign same_set = bus.touch_en && (bus.touch_set == bus.inv_set);

    always_comb begin
        t_en = '0;
        i_en = '0;
        for (int s = 0; s < SETS; s++) begin
            t_en[s] = bus.touch_en && (int'(bus.touch_set) == s);
            i_en[s] = bus.inv_en && (int'(bus.inv_set) == s) && !same_set;
        end
    end

    for (genvar s = 0; s < SETS; s++) begin : g_set
        lru_set_order #(.WAYS(WAYS)) u_set (
            .clk         (clk),
            .rst_n       (rst_n),
            .touch_en_i  (t_en[s]),
            .touch_way_i (bus.touch_way),
            .inv_en_i    (i_en[s]),
            .inv_way_i   (bus.inv_way),
            .lru_o       (lru_s[s]),
            .mru_o       (mru_s[s]),
            .order_o     (ord_s[s])
        );
    end

    // Out-of-range query reports way 0 on both outputs.
    always_comb begin
        bus.lru_way = '0;
        bus.mru_way = '0;
        for (int s = 0; s < SETS; s++) begin
            if (int'(bus.query_set) == s) begin
                bus.lru_way = lru_s[s];
                bus.mru_way = mru_s[s];
            end
        end
    end

    function automatic logic is_perm(input logic [WAYS*WAY_BITS-1:0] v);
        logic [WAYS-1:0] seen;
        seen = '0;
        for (int p = 0; p < WAYS; p++) begin
            seen[v[p*WAY_BITS +: WAY_BITS]] = 1'b1;
        end
        return &seen;
    endfunction

    always_comb begin
        for (int s = 0; s < SETS; s++) begin
            perm_ok[s] = is_perm(ord_s[s]);
        end
    end

    a_consistent: assert property (@(posedge clk) disable iff (!rst_n || !DEBUG)
        (&perm_ok) && ((int'(bus.query_set) >= SETS) || (bus.lru_way != bus.mru_way)));

endmodule
